// File: rtl/multicycle_state_seq.sv
// multicycle_state_seq
// Registered phase sequencer for the multi-cycle CPU (IF/ID/EXE/MEM/WB).
// The state advances once per cycle from a latched opcode class and honours
// stall, memory-wait and a sticky halt.
//
// Optional feature macro: MULTICYCLE_PERF_CNT_EN (adds perf_instr/perf_cycles).
//
// Ports:
//   CLK          in   rising-edge clock
//   RST_n        in   asynchronous active-low reset
//   opcode       in   instruction opcode, sampled while in ID
//   stall        in   freeze state and all registers this cycle
//   mem_ready    in   memory access complete (IF fetch, MEM load/store)
//   state        out  current state register
//   next_state   out  combinational next state (equals state when held)
//   ir_write     out  combinational: IF completes this cycle
//   instr_done   out  combinational: leaving a non-IF state for IF
//   halted       out  sticky halt flag
//   instr_cycles out  saturating cycle count of the current instruction
//   perf_instr   out  (macro only) retired instruction count, wraps
//   perf_cycles  out  (macro only) non-halted cycle count, wraps
module multicycle_state_seq #(
  parameter int unsigned          OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0]  BEQ_OP   = 6'b110100,
  parameter logic [OPCODE_W-1:0]  LW_OP    = 6'b110001,
  parameter logic [OPCODE_W-1:0]  HALT_OP  = 6'b111111,
  parameter bit                   MEM_WAIT = 1'b1,
  parameter int unsigned          CNT_W    = 4
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic [2:0]          next_state,
  output logic                ir_write,
  output logic                instr_done,
  output logic                halted,
`ifdef MULTICYCLE_PERF_CNT_EN
  output logic [31:0]         perf_instr,
  output logic [31:0]         perf_cycles,
`endif
  output logic [CNT_W-1:0]    instr_cycles
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_AEXE = 3'b110;
  localparam logic [2:0] S_BEXE = 3'b101;
  localparam logic [2:0] S_CEXE = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_AWB  = 3'b111;
  localparam logic [2:0] S_CWB  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OPCODE_W-1:0] op_q;
  logic [2:0]          op_class;
  logic                mem_wait;
  logic                hold;
  logic                leave_id;
  logic                entering_if;

  assign op_class = opcode[OPCODE_W-1 -: 3];

  // Memory wait only applies to the phases that touch memory.
  assign mem_wait    = MEM_WAIT && ((state == S_IF) || (state == S_MEM)) && !mem_ready;
  assign hold        = stall || halted || mem_wait;
  assign leave_id    = (state == S_ID) && !hold;
  assign entering_if = (next_state == S_IF) && (state != S_IF);

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; everything after ID looks at op_q, not the live opcode
  always_comb begin
    next_state = S_IF;
    if (hold) begin
      next_state = state;
    end else begin
      case (state)
        S_IF:   next_state = S_ID;
        S_ID: begin
          if (opcode == HALT_OP) begin
            next_state = S_IF;
          end else begin
            case (op_class)
              3'b110:  next_state = (opcode == BEQ_OP) ? S_BEXE : S_CEXE;
              3'b111:  next_state = S_IF;
              default: next_state = S_AEXE;
            endcase
          end
        end
        S_AEXE: next_state = S_AWB;
        S_BEXE: next_state = S_IF;
        S_CEXE: next_state = S_MEM;
        S_MEM:  next_state = (op_q == LW_OP) ? S_CWB : S_IF;
        S_AWB:  next_state = S_IF;
        S_CWB:  next_state = S_IF;
        default: next_state = S_IF;
      endcase
    end
  end

  // Control pulses
  always_comb begin
    ir_write   = 1'b0;
    instr_done = 1'b0;
    if (!hold) begin
      ir_write   = (state == S_IF);
      instr_done = entering_if;
    end
  end

  // Opcode latch and sticky halt
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      op_q   <= '0;
      halted <= 1'b0;
    end else if (leave_id) begin
      op_q <= opcode;
      if (opcode == HALT_OP) begin
        halted <= 1'b1;
      end
    end
  end

  // Per-instruction cycle counter: memory-wait cycles still count,
  // stall and halt freeze it.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      instr_cycles <= '0;
    end else if (!stall && !halted) begin
      if (entering_if) begin
        instr_cycles <= '0;
      end else if (instr_cycles != CNT_MAX) begin
        instr_cycles <= instr_cycles + CNT_W'(1);
      end
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  // Free-running performance counters, wrap modulo 2^32
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      perf_instr  <= '0;
      perf_cycles <= '0;
    end else begin
      if (instr_done) begin
        perf_instr <= perf_instr + 32'd1;
      end
      if (!halted) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_state_seq.sv
// Directed self-checking bench for multicycle_state_seq.
module tb_multicycle_state_seq;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic       CLK;
  logic       RST_n;
  logic [5:0] opcode;
  logic       stall;
  logic       mem_ready;
  logic [2:0] state;
  logic [2:0] next_state;
  logic       ir_write;
  logic       instr_done;
  logic       halted;
  logic [3:0] instr_cycles;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_cycles;
`endif

  int n_tests;
  int n_fail;

  multicycle_state_seq dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .opcode       (opcode),
    .stall        (stall),
    .mem_ready    (mem_ready),
    .state        (state),
    .next_state   (next_state),
    .ir_write     (ir_write),
    .instr_done   (instr_done),
    .halted       (halted),
`ifdef MULTICYCLE_PERF_CNT_EN
    .perf_instr   (perf_instr),
    .perf_cycles  (perf_cycles),
`endif
    .instr_cycles (instr_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset;
    RST_n = 1'b0; stall = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if (state !== 3'b000 || next_state !== 3'b000) begin
      n_fail++; $display("FAIL reset_state: state=%b next=%b expected 000/000", state, next_state);
    end
    n_tests++;
    if (halted !== 1'b0 || instr_cycles !== 4'd0) begin
      n_fail++; $display("FAIL reset_regs: halted=%b cycles=%0d expected 0/0", halted, instr_cycles);
    end
    n_tests++;
    if (ir_write !== 1'b0 || instr_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: ir_write=%b instr_done=%b expected 0/0", ir_write, instr_done);
    end
    RST_n = 1'b1;
  endtask

  task automatic test_rtype;
    logic [2:0] es [5];
    logic [3:0] ec [5];
    logic       ed [5];
    logic       ew [5];
    es = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b000};
    ec = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ew = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      opcode = OP_R; stall = 1'b0; mem_ready = 1'b1;
      #1;
      n_tests++;
      if (state !== es[i] || instr_cycles !== ec[i] || instr_done !== ed[i] || ir_write !== ew[i]) begin
        n_fail++;
        $display("FAIL rtype[%0d]: state=%b cyc=%0d done=%b irw=%b expected %b %0d %b %b",
                 i, state, instr_cycles, instr_done, ir_write, es[i], ec[i], ed[i], ew[i]);
      end
      if (i != 4) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic test_lw_wait;
    logic [2:0] es [8];
    logic [2:0] en [8];
    logic [3:0] ec [8];
    logic       ed [8];
    logic       ew [8];
    logic       mr [8];
    es = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b100, 3'b000};
    en = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b100, 3'b000, 3'b001};
    ec = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ew = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 2) ? OP_LW : OP_R;
      stall = 1'b0; mem_ready = mr[i];
      #1;
      n_tests++;
      if (state !== es[i] || next_state !== en[i] || instr_cycles !== ec[i] ||
          instr_done !== ed[i] || ir_write !== ew[i]) begin
        n_fail++;
        $display("FAIL lw[%0d]: state=%b next=%b cyc=%0d done=%b irw=%b expected %b %b %0d %b %b",
                 i, state, next_state, instr_cycles, instr_done, ir_write, es[i], en[i], ec[i], ed[i], ew[i]);
      end
      if (i != 7) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic test_beq_sw;
    logic [2:0] es [8];
    logic [2:0] en [8];
    logic [3:0] ec [8];
    logic       ed [8];
    logic       ew [8];
    es = '{3'b000, 3'b001, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
    en = '{3'b001, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b001};
    ec = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ew = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 3) ? OP_BEQ : OP_SW;
      stall = 1'b0; mem_ready = 1'b1;
      #1;
      n_tests++;
      if (state !== es[i] || next_state !== en[i] || instr_cycles !== ec[i] ||
          instr_done !== ed[i] || ir_write !== ew[i]) begin
        n_fail++;
        $display("FAIL beq_sw[%0d]: state=%b next=%b cyc=%0d done=%b irw=%b expected %b %b %0d %b %b",
                 i, state, next_state, instr_cycles, instr_done, ir_write, es[i], en[i], ec[i], ed[i], ew[i]);
      end
      if (i != 7) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic test_stall;
    logic [2:0] es [14];
    logic [2:0] en [14];
    logic [3:0] ec [14];
    logic       ed [14];
    logic       ew [14];
    logic       st [14];
    logic       mr [14];
    es = '{3'b000, 3'b001, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111,
           3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b000};
    en = '{3'b001, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b000,
           3'b001, 3'b010, 3'b011, 3'b011, 3'b011, 3'b000, 3'b001};
    ec = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3,
           4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ew = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      if (i >= 2 && i <= 4) opcode = OP_LW;
      else if (i < 7)       opcode = OP_R;
      else                  opcode = OP_SW;
      stall = st[i]; mem_ready = mr[i];
      #1;
      n_tests++;
      if (state !== es[i] || next_state !== en[i] || instr_cycles !== ec[i] ||
          instr_done !== ed[i] || ir_write !== ew[i]) begin
        n_fail++;
        $display("FAIL stall[%0d]: state=%b next=%b cyc=%0d done=%b irw=%b expected %b %b %0d %b %b",
                 i, state, next_state, instr_cycles, instr_done, ir_write, es[i], en[i], ec[i], ed[i], ew[i]);
      end
      if (i != 13) begin @(posedge CLK); #1; end
    end
    stall = 1'b0;
  endtask

  task automatic test_saturate;
    logic [3:0] exp_c;
    // 18 fetch-wait cycles: counter climbs and sticks at 15
    for (int i = 0; i < 18; i++) begin
      opcode = OP_R; stall = 1'b0; mem_ready = 1'b0;
      #1;
      exp_c = (i > 15) ? 4'd15 : 4'(i);
      n_tests++;
      if (state !== 3'b000 || next_state !== 3'b000 || ir_write !== 1'b0 || instr_cycles !== exp_c) begin
        n_fail++;
        $display("FAIL sat_wait[%0d]: state=%b next=%b irw=%b cyc=%0d expected 000 000 0 %0d",
                 i, state, next_state, ir_write, instr_cycles, exp_c);
      end
      @(posedge CLK); #1;
    end
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if (ir_write !== 1'b1 || instr_cycles !== 4'd15) begin
      n_fail++; $display("FAIL sat_fetch: irw=%b cyc=%0d expected 1 15", ir_write, instr_cycles);
    end
    repeat (3) begin @(posedge CLK); #1; end
    n_tests++;
    if (state !== 3'b111 || instr_cycles !== 4'd15 || instr_done !== 1'b1) begin
      n_fail++; $display("FAIL sat_awb: state=%b cyc=%0d done=%b expected 111 15 1", state, instr_cycles, instr_done);
    end
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 3'b000 || instr_cycles !== 4'd0) begin
      n_fail++; $display("FAIL sat_clear: state=%b cyc=%0d expected 000 0", state, instr_cycles);
    end
  endtask

  task automatic test_async_reset;
    opcode = OP_R; stall = 1'b0; mem_ready = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    n_tests++;
    if (state !== 3'b110) begin
      n_fail++; $display("FAIL arst_pre: state=%b expected 110", state);
    end
    #2;
    RST_n = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'b000 || instr_cycles !== 4'd0) begin
      n_fail++; $display("FAIL arst_abort: state=%b cyc=%0d expected 000 0", state, instr_cycles);
    end
    @(posedge CLK); #1;
    RST_n = 1'b1;
  endtask

  task automatic test_halt;
    opcode = OP_HALT; stall = 1'b0; mem_ready = 1'b1;
    #1;
    n_tests++;
    if (state !== 3'b000 || ir_write !== 1'b1) begin
      n_fail++; $display("FAIL halt_if: state=%b irw=%b expected 000 1", state, ir_write);
    end
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 3'b001 || next_state !== 3'b000 || instr_done !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_id: state=%b next=%b done=%b halted=%b expected 001 000 1 0",
                         state, next_state, instr_done, halted);
    end
    @(posedge CLK); #1;
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom); stall = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      n_tests++;
      if (state !== 3'b000 || next_state !== 3'b000 || halted !== 1'b1 ||
          ir_write !== 1'b0 || instr_done !== 1'b0 || instr_cycles !== 4'd0) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: state=%b next=%b halted=%b irw=%b done=%b cyc=%0d expected 000 000 1 0 0 0",
                 i, state, next_state, halted, ir_write, instr_done, instr_cycles);
      end
      @(posedge CLK); #1;
    end
    #2;
    RST_n = 1'b0;
    #1;
    n_tests++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_clear: halted=%b expected 0", halted);
    end
    @(posedge CLK); #1;
    RST_n = 1'b1; opcode = OP_R; stall = 1'b0; mem_ready = 1'b1;
    #1;
    n_tests++;
    if (state !== 3'b000 || ir_write !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume_if: state=%b irw=%b expected 000 1", state, ir_write);
    end
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 3'b001) begin
      n_fail++; $display("FAIL halt_resume_id: state=%b expected 001", state);
    end
  endtask

`ifdef MULTICYCLE_PERF_CNT_EN
  task automatic test_perf;
    RST_n = 1'b0; opcode = OP_R; stall = 1'b0; mem_ready = 1'b1;
    #1;
    n_tests++;
    if (perf_instr !== 32'd0 || perf_cycles !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: instr=%0d cycles=%0d expected 0 0", perf_instr, perf_cycles);
    end
    @(posedge CLK); #1;
    RST_n = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    n_tests++;
    if (perf_instr !== 32'd10 || perf_cycles !== 32'd40 || state !== 3'b000) begin
      n_fail++; $display("FAIL perf_count: instr=%0d cycles=%0d state=%b expected 10 40 000",
                         perf_instr, perf_cycles, state);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq_sw();
    test_stall();
    test_saturate();
    test_async_reset();
    test_halt();
`ifdef MULTICYCLE_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
